// File: rtl/apb_rr_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : apb_rr_master_if
//  Purpose  : Bundles the two requester command/response channels and the
//             APB3 bus of the round-robin APB master.
//  Revision : 1.0  initial release
// ============================================================================
interface apb_rr_master_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();
    // Requester 0
    logic              req0_valid;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;
    // Requester 1
    logic              req1_valid;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;
    // APB3
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;

    // Arbitrating APB master side
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output paddr, psel, penable, pwrite, pwdata,
        input  pready, prdata
    );

    // APB slave side
    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output pready, prdata
    );
endinterface
`default_nettype wire

// File: rtl/apb_rr_master.sv
`default_nettype none
// ============================================================================
//  Module   : apb_rr_master
//  Purpose  : Two-port APB3 master; round-robin arbitration between two
//             valid/ready requesters, wait-state handling and timeout abort.
//  Revision : 1.0  initial release
// ============================================================================
module apb_rr_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            pclk,
    input  logic            presetn,
    apb_rr_master_if.master bus
);
    localparam int C_CNT_W = $clog2(TIMEOUT);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               owner_q, owner_d;          // requester of the in-flight txn
    logic               last_grant_q, last_grant_d;
    logic [C_CNT_W-1:0] cnt_q, cnt_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp0_err_q, rsp0_err_d;
    logic [DATA_W-1:0]  rsp0_rdata_q, rsp0_rdata_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic               rsp1_err_q, rsp1_err_d;
    logic [DATA_W-1:0]  rsp1_rdata_q, rsp1_rdata_d;

    logic               w_grant0, w_grant1;
    logic               w_finish, w_err;
    logic [DATA_W-1:0]  w_rdata;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        w_grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        w_grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    end

    assign bus.req0_ready = presetn & (state_q == ST_IDLE) & w_grant0;
    assign bus.req1_ready = presetn & (state_q == ST_IDLE) & w_grant1;

    // Next-state logic for the transfer sequencer and response registers
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        rsp0_valid_d = 1'b0;
        rsp0_err_d   = rsp0_err_q;
        rsp0_rdata_d = rsp0_rdata_q;
        rsp1_valid_d = 1'b0;
        rsp1_err_d   = rsp1_err_q;
        rsp1_rdata_d = rsp1_rdata_q;
        w_finish     = 1'b0;
        w_err        = 1'b0;
        w_rdata      = '0;

        case (state_q)
            ST_IDLE: begin
                if (w_grant0 | w_grant1) begin
                    pwrite_d     = w_grant1 ? bus.req1_write : bus.req0_write;
                    paddr_d      = w_grant1 ? bus.req1_addr  : bus.req0_addr;
                    pwdata_d     = w_grant1 ? bus.req1_wdata : bus.req0_wdata;
                    owner_d      = w_grant1;
                    last_grant_d = w_grant1;
                    psel_d       = 1'b1;
                    penable_d    = 1'b0;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (bus.pready) begin
                    w_finish = 1'b1;
                end else if (cnt_q == C_CNT_LAST) begin
                    w_finish = 1'b1;
                    w_err    = 1'b1;
                end else begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                cnt_d     = '0;
            end
        endcase

        // Completion or abort: release the bus and pulse the owner's response
        if (w_finish) begin
            state_d   = ST_IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
            cnt_d     = '0;
            w_rdata   = (w_err | pwrite_q) ? '0 : bus.prdata;
            if (owner_q) begin
                rsp1_valid_d = 1'b1;
                rsp1_rdata_d = w_rdata;
                rsp1_err_d   = w_err;
            end else begin
                rsp0_valid_d = 1'b1;
                rsp0_rdata_d = w_rdata;
                rsp0_err_d   = w_err;
            end
        end
    end

    // State and output registers; reset abandons any transfer in progress
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q      <= ST_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            rsp0_valid_q <= 1'b0;
            rsp0_err_q   <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_valid_q <= 1'b0;
            rsp1_err_q   <= 1'b0;
            rsp1_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_err_q   <= rsp0_err_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_err_q   <= rsp1_err_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign bus.psel       = psel_q;
    assign bus.penable    = penable_q;
    assign bus.pwrite     = pwrite_q;
    assign bus.paddr      = paddr_q;
    assign bus.pwdata     = pwdata_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.rsp1_err   = rsp1_err_q;
endmodule
`default_nettype wire

// File: tb/tb_apb_rr_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_rr_master
//  Purpose  : Randomised scoreboard bench for apb_rr_master with an APB RAM
//             slave whose wait states are chosen per transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_rr_master;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    apb_rr_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_rr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    int          wq[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc  = 0;
    int          wmode = 0;
    logic        force_wr = 1'b0;
    logic [31:0] ram [256];
    logic [31:0] mdl [256];
    logic        acc0 = 1'b0;
    logic        acc1 = 1'b0;

    // reference model of the in-flight transfer
    logic        busy = 1'b0;
    int          acc_cyc = 0;
    int          free_cyc = 0;
    logic        last = 1'b1;
    logic [7:0]  f_addr = '0;
    logic        f_write = 1'b0;
    logic [31:0] f_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // wait states the slave will insert for the next transfer
    function automatic int pick_wait();
        int r;
        case (wmode)
            1: return 0;
            2: return 1000;
            default: begin
                r = int'($urandom_range(0, 99));
                if (r < 60)      return 0;
                else if (r < 85) return int'($urandom_range(1, 3));
                else             return int'($urandom_range(TIMEOUT - 3, TIMEOUT + 2));
            end
        endcase
    endfunction

    always @(posedge pclk) cyc <= cyc + 1;

    // model: APB phase checks, arbitration prediction, expected responses
    always @(negedge pclk) begin
        logic e0, e1, p1;
        int   w, lat;
        exp_t e;
        if (busy && cyc == acc_cyc + 1) begin
            check("psel_setup",    bus.psel,    1);
            check("penable_setup", bus.penable, 0);
            check("paddr_setup",   bus.paddr,   f_addr);
            check("pwrite_setup",  bus.pwrite,  f_write);
        end else if (busy && cyc < free_cyc) begin
            check("psel_access",    bus.psel,    1);
            check("penable_access", bus.penable, 1);
            check("paddr_access",   bus.paddr,   f_addr);
            check("pwrite_access",  bus.pwrite,  f_write);
            if (f_write) check("pwdata_access", bus.pwdata, f_wdata);
        end else begin
            check("psel_idle",    bus.psel,    0);
            check("penable_idle", bus.penable, 0);
        end
        if (busy && cyc >= free_cyc) busy = 1'b0;

        e0 = 1'b0;
        e1 = 1'b0;
        if (presetn && cyc >= free_cyc) begin
            if (bus.req0_valid && bus.req1_valid) begin
                e0 = last;
                e1 = !last;
            end else begin
                e0 = bus.req0_valid;
                e1 = bus.req1_valid;
            end
        end
        check("req0_ready", bus.req0_ready, e0);
        check("req1_ready", bus.req1_ready, e1);

        if (!presetn) begin
            q0.delete();
            q1.delete();
            wq.delete();
            busy     = 1'b0;
            free_cyc = 0;
            last     = 1'b1;
        end else if (e0 || e1) begin
            p1       = e1;
            w        = pick_wait();
            lat      = 3 + ((w < TIMEOUT - 1) ? w : TIMEOUT - 1);
            f_write  = p1 ? bus.req1_write : bus.req0_write;
            f_addr   = p1 ? bus.req1_addr  : bus.req0_addr;
            f_wdata  = p1 ? bus.req1_wdata : bus.req0_wdata;
            e.err    = (w > TIMEOUT - 1);
            e.rdata  = (e.err || f_write) ? 32'h0 : mdl[f_addr];
            e.cyc    = cyc + lat;
            if (f_write && !e.err) mdl[f_addr] = f_wdata;
            if (p1) q1.push_back(e);
            else    q0.push_back(e);
            wq.push_back(w);
            busy     = 1'b1;
            acc_cyc  = cyc;
            free_cyc = cyc + lat;
            last     = p1;
        end
        acc0 = e0;
        acc1 = e1;
    end

    task automatic chk_port(input int p);
        exp_t e;
        logic v, due;
        v   = (p == 1) ? bus.rsp1_valid : bus.rsp0_valid;
        due = 1'b0;
        if (p == 0 && q0.size() > 0 && q0[0].cyc == cyc) begin
            due = 1'b1;
            e   = q0.pop_front();
        end
        if (p == 1 && q1.size() > 0 && q1[0].cyc == cyc) begin
            due = 1'b1;
            e   = q1.pop_front();
        end
        if (due) begin
            check((p == 1) ? "rsp1_valid" : "rsp0_valid", v, 1);
            if (v) begin
                check((p == 1) ? "rsp1_rdata" : "rsp0_rdata",
                      (p == 1) ? bus.rsp1_rdata : bus.rsp0_rdata, e.rdata);
                check((p == 1) ? "rsp1_err" : "rsp0_err",
                      (p == 1) ? bus.rsp1_err : bus.rsp0_err, e.err);
            end
        end else begin
            check((p == 1) ? "rsp1_unexpected" : "rsp0_unexpected", v, 0);
        end
    endtask

    // monitor: pops the scoreboard whenever a response is due or appears
    always @(negedge pclk) begin
        chk_port(0);
        chk_port(1);
    end

    // APB RAM slave with per-transfer wait states
    initial begin
        int rem;
        rem        = 0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        forever begin
            @(posedge pclk);
            #1;
            if (bus.psel && !bus.penable) begin
                rem        = (wq.size() > 0) ? wq.pop_front() : 0;
                bus.pready = 1'b0;
                bus.prdata = $urandom;
            end else if (bus.psel && bus.penable) begin
                bus.pready = (rem == 0);
                bus.prdata = ram[bus.paddr];
                if (rem == 0 && bus.pwrite) ram[bus.paddr] = bus.pwdata;
                if (rem > 0) rem--;
            end else begin
                bus.pready = 1'(($urandom_range(0, 1)));
                bus.prdata = $urandom;
            end
        end
    end

    task automatic drive_port(input int p, input logic en, input logic always_v);
        logic cur, acc, v;
        cur = (p == 1) ? bus.req1_valid : bus.req0_valid;
        acc = (p == 1) ? acc1 : acc0;
        if (en && cur && !acc && (always_v || $urandom_range(0, 19) != 0)) return;
        v = en && (always_v || $urandom_range(0, 2) != 0);
        if (p == 0) begin
            bus.req0_valid = v;
            bus.req0_write = force_wr | 1'($urandom_range(0, 1));
            bus.req0_addr  = 8'($urandom_range(0, 7));
            bus.req0_wdata = $urandom;
        end else begin
            bus.req1_valid = v;
            bus.req1_write = force_wr | 1'($urandom_range(0, 1));
            bus.req1_addr  = 8'($urandom_range(0, 7));
            bus.req1_wdata = $urandom;
        end
    endtask

    task automatic run(input int n, input logic en0, input logic en1, input logic always_v);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk);
            #1;
            drive_port(0, en0, always_v);
            drive_port(1, en1, always_v);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hit;
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            mdl[i] = ram[i];
        end
        bus.req0_valid = 1'b1;
        bus.req0_write = 1'b1;
        bus.req0_addr  = 8'h10;
        bus.req0_wdata = 32'hDEADBEEF;
        bus.req1_valid = 1'b1;
        bus.req1_write = 1'b0;
        bus.req1_addr  = 8'h10;
        bus.req1_wdata = '0;

        // reset state, with both requesters asserting valid
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check("rst_psel",       bus.psel,       0);
        check("rst_penable",    bus.penable,    0);
        check("rst_pwrite",     bus.pwrite,     0);
        check("rst_paddr",      bus.paddr,      0);
        check("rst_pwdata",     bus.pwdata,     0);
        check("rst_rsp0_rdata", bus.rsp0_rdata, 0);
        check("rst_rsp0_err",   bus.rsp0_err,   0);
        check("rst_rsp1_rdata", bus.rsp1_rdata, 0);
        check("rst_rsp1_err",   bus.rsp1_err,   0);

        // release with a tie: write 0x10 from port 0 then read it back on port 1
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        wmode   = 1;
        run(20, 1'b1, 1'b1, 1'b1);

        // mixed random traffic, random wait states around the timeout boundary
        wmode = 0;
        run(900, 1'b1, 1'b1, 1'b0);

        // slave never ready: every transfer aborts, then normal service resumes
        wmode = 2;
        run(60, 1'b1, 1'b0, 1'b0);
        wmode = 1;
        run(20, 1'b1, 1'b0, 1'b0);

        // reset in the middle of an ACCESS phase
        wmode = 2;
        hit   = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            run(1, 1'b1, 1'b0, 1'b1);
            hit = bus.psel && bus.penable;
        end
        check("reach_access", hit, 1);
        presetn        = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(posedge pclk);
        #1;
        presetn = 1'b1;
        wmode   = 1;
        run(30, 1'b1, 1'b1, 1'b1);

        // port 0 alone, back-to-back writes
        force_wr = 1'b1;
        run(15, 1'b1, 1'b0, 1'b1);
        force_wr = 1'b0;

        // drain
        run(40, 1'b0, 1'b0, 1'b0);
        check("drain_q0", q0.size(), 0);
        check("drain_q1", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
